// File: rtl/whack_a_mole_core_n.sv
// Whack-a-mole game engine: picks non-repeating random holes from an 8-bit
// LFSR, scores edge-detected switch hits and counts timeouts/penalties as misses.
module whack_a_mole_core_n #(
  parameter int          N_HOLES    = 9,
  parameter int          CNT_W      = 33,
  parameter int          SCORE_W    = 7,
  parameter logic [63:0] GAME_TICKS = 64'd6000000000,
  parameter logic [63:0] TICKS_EASY = 64'd3000000000,
  parameter logic [63:0] TICKS_MED  = 64'd2000000000,
  parameter logic [63:0] TICKS_HARD = 64'd1000000000,
  parameter int          PENALTY    = 0,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               BtnL,
  input  logic               BtnU,
  input  logic               BtnR,
  input  logic               Ack,
  input  logic [N_HOLES-1:0] Sw,
  output logic               mole_valid,
  output logic [3:0]         mole_index,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               start_game,
  output logic               game_timer_out,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    UP   = 3'd2,
    HIT  = 3'd3,
    MISS = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]   GAME_LAST = CNT_W'(GAME_TICKS - 64'd1);
  localparam logic [CNT_W-1:0]   EASY_LAST = CNT_W'(TICKS_EASY - 64'd1);
  localparam logic [CNT_W-1:0]   MED_LAST  = CNT_W'(TICKS_MED - 64'd1);
  localparam logic [CNT_W-1:0]   HARD_LAST = CNT_W'(TICKS_HARD - 64'd1);
  localparam logic [3:0]         LAST_HOLE = 4'(N_HOLES - 1);
  localparam logic [7:0]         HOLES_8   = 8'(N_HOLES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t             state;
  state_t             state_next;
  logic [7:0]         lfsr;
  logic               lfsr_fb;
  logic [N_HOLES-1:0] sw_q;
  logic [N_HOLES-1:0] rise;
  logic               hit_rise;
  logic [3:0]         cand;
  logic               first_mole;
  logic [CNT_W-1:0]   game_cnt;
  logic [CNT_W-1:0]   mole_cnt;
  logic [CNT_W-1:0]   win_last;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign state_o = state;

  // Candidate hole is bumped by one when it would repeat the previous mole.
  always_comb begin
    rise     = Sw & ~sw_q;
    hit_rise = |(rise & (N_HOLES'(1) << mole_index));
    cand     = 4'(lfsr % HOLES_8);
    if (!first_mole && (cand == mole_index)) begin
      cand = (cand == LAST_HOLE) ? 4'd0 : cand + 4'd1;
    end
    state_next = state;
    case (state)
      IDLE: if (BtnL || BtnU || BtnR) state_next = ARM;
      ARM:  state_next = UP;
      UP: begin
        if (hit_rise)                            state_next = HIT;
        else if ((PENALTY != 0) && (|rise))      state_next = MISS;
        else if (mole_cnt == win_last)           state_next = MISS;
        else if (game_timer_out)                 state_next = DONE;
      end
      HIT, MISS: state_next = game_timer_out ? DONE : ARM;
      DONE: if (Ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr           <= LFSR_SEED;
      sw_q           <= '0;
      mole_valid     <= 1'b0;
      mole_index     <= 4'd0;
      score          <= '0;
      misses         <= '0;
      hit_pulse      <= 1'b0;
      miss_pulse     <= 1'b0;
      start_game     <= 1'b0;
      game_timer_out <= 1'b0;
      first_mole     <= 1'b0;
      game_cnt       <= '0;
      mole_cnt       <= '0;
      win_last       <= '0;
    end else begin
      lfsr       <= {lfsr[6:0], lfsr_fb};
      sw_q       <= Sw;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      if (start_game && !game_timer_out) begin
        if (game_cnt == GAME_LAST) game_timer_out <= 1'b1;
        else                       game_cnt       <= game_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (BtnL || BtnU || BtnR) begin
            win_last       <= BtnL ? EASY_LAST : (BtnU ? MED_LAST : HARD_LAST);
            score          <= '0;
            misses         <= '0;
            game_cnt       <= '0;
            game_timer_out <= 1'b0;
            start_game     <= 1'b1;
            first_mole     <= 1'b1;
          end
        end
        ARM: begin
          mole_index <= cand;
          mole_valid <= 1'b1;
          mole_cnt   <= '0;
          first_mole <= 1'b0;
        end
        UP: mole_cnt <= mole_cnt + CNT_W'(1);
        HIT: begin
          mole_valid <= 1'b0;
          hit_pulse  <= 1'b1;
          if (score != SCORE_MAX) score <= score + SCORE_W'(1);
        end
        MISS: begin
          mole_valid <= 1'b0;
          miss_pulse <= 1'b1;
          if (misses != SCORE_MAX) misses <= misses + SCORE_W'(1);
        end
        DONE: begin
          if (Ack) begin
            score          <= '0;
            misses         <= '0;
            game_timer_out <= 1'b0;
            mole_index     <= 4'd0;
          end
        end
        default: ;
      endcase

      // Entering DONE hides the mole and stops the game clock immediately.
      if (state_next == DONE) begin
        mole_valid <= 1'b0;
        start_game <= 1'b0;
      end
    end
  end

endmodule
